// File: rtl/stopwatch_display_scanner.sv
// Four-digit BCD stopwatch (SS.hh) with a free-running digit-scan multiplexer feeding a hex display decoder.
// Digits change on the tick edge; BINARY/DOT follow the registered digits and SEGMENT combinationally.
module stopwatch_display_scanner #(
  parameter int TICK_DIV = 1_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START_STOP,
  input  logic       CLEAR,
  output logic [3:0] BINARY,
  output logic [1:0] SEGMENT,
  output logic       DOT,
  output logic       ROLLOVER
);

  // Keep counters at least one bit wide so a divide-by-1 still elaborates.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  state_t          state;
  logic [TW-1:0]   presc;
  logic [SW-1:0]   scan_cnt;
  logic [3:0][3:0] dig;
  logic [3:0][3:0] dig_next;
  logic [4:0]      carry;
  logic            tick;

  // carry[4] set means every digit wrapped: 99.99 -> 00.00.
  always_comb begin
    tick     = (state == RUNNING) && (presc == TICK_MAX);
    carry    = '0;
    dig_next = dig;
    carry[0] = tick;
    for (int i = 0; i < 4; i++) begin
      if (carry[i]) begin
        dig_next[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
      end
      carry[i+1] = carry[i] && (dig[i] == 4'd9);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      presc    <= '0;
      dig      <= '0;
      ROLLOVER <= 1'b0;
    end else if (CLEAR) begin
      state    <= IDLE;
      presc    <= '0;
      dig      <= '0;
      ROLLOVER <= 1'b0;
    end else begin
      ROLLOVER <= carry[4];
      if (state == RUNNING) begin
        presc <= tick ? '0 : presc + TW'(1);
        dig   <= dig_next;
      end
      if (START_STOP) begin
        case (state)
          IDLE:    state <= RUNNING;
          RUNNING: state <= PAUSED;
          PAUSED:  state <= RUNNING;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Scan runs in every state and ignores CLEAR so the display keeps refreshing.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt <= '0;
      SEGMENT  <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      SEGMENT  <= SEGMENT + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign BINARY = dig[SEGMENT];
  assign DOT    = (SEGMENT == 2'd2);

endmodule

// File: tb/tb_stopwatch_display_scanner.sv
// Directed bench for stopwatch_display_scanner at TICK_DIV=4, SCAN_DIV=2.
module tb_stopwatch_display_scanner;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START_STOP;
  logic       CLEAR;
  logic [3:0] BINARY;
  logic [1:0] SEGMENT;
  logic       DOT;
  logic       ROLLOVER;

  int checks = 0;
  int failures = 0;

  stopwatch_display_scanner #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .CLK(CLK), .RESET(RESET), .START_STOP(START_STOP), .CLEAR(CLEAR),
    .BINARY(BINARY), .SEGMENT(SEGMENT), .DOT(DOT), .ROLLOVER(ROLLOVER)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ss;
    logic        clr;
    int          n;
    logic [15:0] cnt;
    logic        roll;
  } vec_t;

  typedef struct {
    logic [1:0] seg;
    logic [3:0] bin;
    logic       dot;
  } scan_t;

  vec_t  vecs[15];
  scan_t scans[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] count_now();
    return 16'(dut.dig);
  endfunction

  // Drive the controls for exactly one rising edge, then release them.
  task automatic pulse(input logic ss, input logic clr);
    START_STOP = ss;
    CLEAR = clr;
    @(posedge CLK);
    #1;
    START_STOP = 1'b0;
    CLEAR = 1'b0;
  endtask

  initial begin
    logic [1:0] prev_seg;
    bit         synced;

    // Row: controls on the first of n edges, then count/ROLLOVER compared.
    vecs[0]  = '{1'b1, 1'b0, 36,  16'h0008, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1,   16'h0009, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 3,   16'h0009, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1,   16'h0010, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1,   16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 26,  16'h0006, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1,   16'h0006, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 100, 16'h0006, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1,   16'h0006, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1,   16'h0006, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1,   16'h0007, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1,   16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 21,  16'h0005, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1,   16'h0000, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 20,  16'h0000, 1'b0};

    scans[0] = '{2'd0, 4'd4, 1'b0};
    scans[1] = '{2'd0, 4'd4, 1'b0};
    scans[2] = '{2'd1, 4'd3, 1'b0};
    scans[3] = '{2'd1, 4'd3, 1'b0};
    scans[4] = '{2'd2, 4'd2, 1'b1};
    scans[5] = '{2'd2, 4'd2, 1'b1};
    scans[6] = '{2'd3, 4'd1, 1'b0};
    scans[7] = '{2'd3, 4'd1, 1'b0};
    scans[8] = '{2'd0, 4'd4, 1'b0};

    START_STOP = 1'b0;
    CLEAR = 1'b0;
    RESET = 1'b0;
    #1 RESET = 1'b1;
    #1;
    check("rst_binary", 32'(BINARY), 0);
    check("rst_segment", 32'(SEGMENT), 0);
    check("rst_dot", 32'(DOT), 0);
    check("rst_rollover", 32'(ROLLOVER), 0);
    check("rst_count", 32'(count_now()), 0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset raised between edges while running at 00.03.
    pulse(1'b1, 1'b0);
    repeat (12) @(posedge CLK);
    #1;
    check("midrun_count", 32'(count_now()), 32'h0003);
    #3 RESET = 1'b1;
    #1;
    check("async_binary", 32'(BINARY), 0);
    check("async_segment", 32'(SEGMENT), 0);
    check("async_dot", 32'(DOT), 0);
    check("async_rollover", 32'(ROLLOVER), 0);
    check("async_count", 32'(count_now()), 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    check("post_reset_idle", 32'(count_now()), 0);

    for (int i = 0; i < 15; i++) begin
      pulse(vecs[i].ss, vecs[i].clr);
      for (int k = 1; k < vecs[i].n; k++) begin
        @(posedge CLK);
        #1;
      end
      check($sformatf("vec%0d_count", i), 32'(count_now()), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_rollover", i), 32'(ROLLOVER), 32'(vecs[i].roll));
    end

    // Rollover: 9999 ticks, then the wrapping tick.
    pulse(1'b1, 1'b0);
    repeat (39995) @(posedge CLK);
    #1;
    check("pre_roll_9998", 32'(count_now()), 32'h9998);
    @(posedge CLK);
    #1;
    check("count_9999", 32'(count_now()), 32'h9999);
    repeat (3) @(posedge CLK);
    #1;
    check("hold_9999", 32'(count_now()), 32'h9999);
    check("no_early_roll", 32'(ROLLOVER), 0);
    @(posedge CLK);
    #1;
    check("wrap_count", 32'(count_now()), 0);
    check("roll_high", 32'(ROLLOVER), 1);
    @(posedge CLK);
    #1;
    check("roll_one_cycle", 32'(ROLLOVER), 0);
    repeat (3) @(posedge CLK);
    #1;
    check("after_wrap_0001", 32'(count_now()), 32'h0001);

    // Park at 12.34 and watch the scan.
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    repeat (4936) @(posedge CLK);
    #1;
    pulse(1'b1, 1'b0);
    check("paused_1234", 32'(count_now()), 32'h1234);
    synced = 1'b0;
    for (int k = 0; k < 20 && !synced; k++) begin
      prev_seg = SEGMENT;
      @(posedge CLK);
      #1;
      if (prev_seg == 2'd3 && SEGMENT == 2'd0) synced = 1'b1;
    end
    check("scan_sync", 32'(synced), 1);
    if (synced) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("scan%0d_segment", i), 32'(SEGMENT), 32'(scans[i].seg));
        check($sformatf("scan%0d_binary", i), 32'(BINARY), 32'(scans[i].bin));
        check($sformatf("scan%0d_dot", i), 32'(DOT), 32'(scans[i].dot));
        @(posedge CLK);
        #1;
      end
    end
    check("scan_hold_1234", 32'(count_now()), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
